// File: rtl/control_maestro.sv
// Bus transaction master: arbitrates write/read/refresh requests and sequences
// DIR -> DAT -> cambio phases until the owning machine signals completion.
module control_maestro #(
  parameter int unsigned T_FASE     = 4,
  parameter int unsigned T_REFRESCO = 1000,
  parameter int unsigned MAX_PASOS  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic Req_Esc,
  input  logic Req_Lect,
  input  logic Term_Lect,
  input  logic Term_Esc,
  output logic Lectura,
  output logic Escritura,
  output logic DIR,
  output logic DAT,
  output logic cambio_estado,
  output logic Ocupado,
  output logic Err_Timeout
);

  localparam int REF_W  = $clog2(T_REFRESCO);
  localparam int PH_W   = 8;
  localparam int STEP_W = $clog2(MAX_PASOS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    F_DIR  = 3'd2,
    F_DAT  = 3'd3,
    F_CAMB = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t              state;
  logic [REF_W-1:0]    ref_cnt;
  logic [PH_W-1:0]     phase_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic                pend_esc;
  logic                pend_lect;
  logic                owner_esc;
  logic                done_lat;
  logic                term_lect_q;
  logic                term_esc_q;

  logic wrap;
  logic term_edge;
  logic phase_end;
  logic last_step;
  logic want_esc;
  logic want_lect;
  logic in_txn;

  assign wrap      = (ref_cnt == REF_W'(T_REFRESCO - 1));
  assign term_edge = owner_esc ? (Term_Esc & ~term_esc_q) : (Term_Lect & ~term_lect_q);
  assign phase_end = (phase_cnt == PH_W'(T_FASE - 1));
  assign last_step = (step_cnt == STEP_W'(MAX_PASOS - 1));
  // Requests and a refresh wrap seen in IDLE compete in the same cycle they arrive.
  assign want_esc  = pend_esc | Req_Esc;
  assign want_lect = pend_lect | Req_Lect | wrap;
  assign in_txn    = (state == GRANT) || (state == F_DIR) || (state == F_DAT) || (state == F_CAMB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt     <= '0;
      term_lect_q <= 1'b0;
      term_esc_q  <= 1'b0;
    end else begin
      ref_cnt     <= wrap ? '0 : ref_cnt + REF_W'(1);
      term_lect_q <= Term_Lect;
      term_esc_q  <= Term_Esc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      phase_cnt     <= '0;
      step_cnt      <= '0;
      pend_esc      <= 1'b0;
      pend_lect     <= 1'b0;
      owner_esc     <= 1'b0;
      done_lat      <= 1'b0;
      Lectura       <= 1'b0;
      Escritura     <= 1'b0;
      DIR           <= 1'b0;
      DAT           <= 1'b0;
      cambio_estado <= 1'b0;
      Ocupado       <= 1'b0;
      Err_Timeout   <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in
      // this block, so every strobe is a clean one-cycle pulse on phase entry.
      Lectura       <= 1'b0;
      Escritura     <= 1'b0;
      DIR           <= 1'b0;
      DAT           <= 1'b0;
      cambio_estado <= 1'b0;
      pend_esc      <= want_esc;
      pend_lect     <= want_lect;
      if (in_txn && term_edge) done_lat <= 1'b1;

      case (state)
        IDLE: begin
          if (want_esc || want_lect) begin
            state       <= GRANT;
            Ocupado     <= 1'b1;
            Err_Timeout <= 1'b0;
            done_lat    <= 1'b0;
            step_cnt    <= '0;
            owner_esc   <= want_esc;
            if (want_esc) begin
              Escritura <= 1'b1;
              pend_esc  <= 1'b0;
            end else begin
              Lectura   <= 1'b1;
              pend_lect <= 1'b0;
            end
          end
        end
        GRANT: begin
          state     <= F_DIR;
          DIR       <= 1'b1;
          phase_cnt <= '0;
        end
        F_DIR: begin
          if (phase_end) begin
            state     <= F_DAT;
            DAT       <= 1'b1;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        F_DAT: begin
          if (phase_end) begin
            state         <= F_CAMB;
            cambio_estado <= 1'b1;
            phase_cnt     <= '0;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        F_CAMB: begin
          if (phase_end) begin
            phase_cnt <= '0;
            // A Term edge in this very cycle still counts as completion.
            if (done_lat || term_edge) begin
              state <= FIN;
            end else if (last_step) begin
              state       <= FIN;
              Err_Timeout <= 1'b1;
            end else begin
              state    <= F_DIR;
              DIR      <= 1'b1;
              step_cnt <= step_cnt + STEP_W'(1);
            end
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        FIN: begin
          state    <= IDLE;
          Ocupado  <= 1'b0;
          done_lat <= 1'b0;
          step_cnt <= '0;
        end
        default: begin
          state   <= IDLE;
          Ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_maestro.sv
// Self-checking bench for control_maestro: transaction-level reference model
// compared every cycle, plus directed timing cases with literal expectations.
module tb_control_maestro;

  localparam int TF = 4;
  localparam int TR = 1000;
  localparam int MP = 16;
  localparam int SL = 3 * TF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_esc = 1'b0;
  logic req_lect = 1'b0;
  logic term_lect = 1'b0;
  logic term_esc = 1'b0;
  logic lectura, escritura, dir, dat, camb, ocupado, err_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  control_maestro #(.T_FASE(TF), .T_REFRESCO(TR), .MAX_PASOS(MP)) dut (
    .clk          (clk),
    .reset        (reset),
    .Req_Esc      (req_esc),
    .Req_Lect     (req_lect),
    .Term_Lect    (term_lect),
    .Term_Esc     (term_esc),
    .Lectura      (lectura),
    .Escritura    (escritura),
    .DIR          (dir),
    .DAT          (dat),
    .cambio_estado(camb),
    .Ocupado      (ocupado),
    .Err_Timeout  (err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks a transaction by its age t (cycles since grant).
  typedef struct packed {
    int rc;
    int t;
    bit pe, pl, busy, fin, own, done, err, hl, he;
  } model_t;

  model_t m;

  function automatic model_t model_step(input model_t s, input bit re, input bit rl,
                                        input bit tl, input bit te);
    model_t n;
    bit wrap, rise;
    n = s;
    wrap = (s.rc == TR - 1);
    n.rc = wrap ? 0 : s.rc + 1;
    rise = s.own ? (te && !s.he) : (tl && !s.hl);
    n.hl = tl;
    n.he = te;
    n.pe = s.pe || re;
    n.pl = s.pl || rl || wrap;
    if (!s.busy) begin
      if (n.pe || n.pl) begin
        n.own = n.pe;
        if (n.pe) n.pe = 1'b0;
        else n.pl = 1'b0;
        n.busy = 1'b1;
        n.t = 0;
        n.fin = 1'b0;
        n.done = 1'b0;
        n.err = 1'b0;
      end
    end else if (s.fin) begin
      n.busy = 1'b0;
      n.fin = 1'b0;
    end else begin
      if (rise) n.done = 1'b1;
      if (s.t > 0 && s.t % SL == 0) begin
        if (n.done) n.fin = 1'b1;
        else if (s.t / SL == MP) begin
          n.fin = 1'b1;
          n.err = 1'b1;
        end
      end
      n.t = s.t + 1;
    end
    return n;
  endfunction

  // Expected {Lectura, Escritura, DIR, DAT, cambio_estado, Ocupado, Err_Timeout}.
  function automatic logic [6:0] model_out(input model_t s);
    logic [6:0] v;
    int r;
    v = '0;
    if (s.busy) begin
      v[1] = 1'b1;
      if (!s.fin) begin
        if (s.t == 0) begin
          v[6] = !s.own;
          v[5] = s.own;
        end else begin
          r = (s.t - 1) % SL;
          v[4] = (r == 0);
          v[3] = (r == TF);
          v[2] = (r == 2 * TF);
        end
      end
    end
    v[0] = s.err;
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '0;
    else m <= model_step(m, req_esc, req_lect, term_lect, term_esc);
  end

  always @(negedge clk)
    check("outputs", {lectura, escritura, dir, dat, camb, ocupado, err_timeout}, model_out(m));

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    int grant, dir1, dir2, dat1, camb1, n_camb, idle;
    bit is_write, err_g;
  } txn_t;

  // Follows one transaction from reference cycle c0 until Ocupado drops,
  // raising the chosen Term flag at cycle term_rel and leaving it high.
  task automatic run_txn(input int c0, input int term_rel, input bit term_w, output txn_t r);
    int rel;
    r.grant = -1; r.dir1 = -1; r.dir2 = -1; r.dat1 = -1; r.camb1 = -1;
    r.n_camb = 0; r.idle = -1; r.is_write = 1'b0; r.err_g = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      req_esc = 1'b0;
      req_lect = 1'b0;
      rel = cyc - c0;
      if ((lectura || escritura) && r.grant < 0) begin
        r.grant = rel;
        r.is_write = escritura;
        r.err_g = err_timeout;
      end
      if (dir) begin
        if (r.dir1 < 0) r.dir1 = rel;
        else if (r.dir2 < 0) r.dir2 = rel;
      end
      if (dat && r.dat1 < 0) r.dat1 = rel;
      if (camb) begin
        r.n_camb++;
        if (r.camb1 < 0) r.camb1 = rel;
      end
      if (rel == term_rel) begin
        if (term_w) term_esc = 1'b1;
        else term_lect = 1'b1;
      end
      if (r.grant >= 0 && !ocupado) begin
        r.idle = rel;
        break;
      end
    end
  endtask

  initial begin
    txn_t r;
    int c0;
    int quiet;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Read on demand: phase timing, completion during the 8th step.
    c0 = cyc; req_lect = 1'b1;
    run_txn(c0, 90, 1'b0, r);
    check("s1_lectura_rel", r.grant, 1);
    check("s1_is_read", r.is_write, 0);
    check("s1_dir_rel", r.dir1, 2);
    check("s1_dat_rel", r.dat1, 6);
    check("s1_camb_rel", r.camb1, 10);
    check("s1_dir_repeat_rel", r.dir2, 14);
    check("s1_camb_count", r.n_camb, 8);
    check("s1_idle_rel", r.idle, 99);
    check("s1_err", err_timeout, 0);

    // Term_Lect still high from before: no edge, so the read times out.
    c0 = cyc; req_lect = 1'b1;
    run_txn(c0, -1, 1'b0, r);
    check("s2_camb_count", r.n_camb, MP);
    check("s2_idle_rel", r.idle, 195);
    check("s2_err_sticky", err_timeout, 1);

    // Next grant clears the timeout flag.
    c0 = cyc; req_esc = 1'b1;
    run_txn(c0, 20, 1'b1, r);
    check("s3_is_write", r.is_write, 1);
    check("s3_err_at_grant", r.err_g, 0);
    check("s3_camb_count", r.n_camb, 2);
    check("s3_idle_rel", r.idle, 27);
    term_esc = 1'b0;
    term_lect = 1'b0;
    tick();

    // Write request coincides with a refresh wrap: write first, read right after.
    for (int i = 0; i < TR + 5 && m.rc != TR - 1; i++) tick();
    c0 = cyc; req_esc = 1'b1;
    run_txn(c0, 20, 1'b1, r);
    check("s4_write_first", r.is_write, 1);
    check("s4_write_grant_rel", r.grant, 1);
    check("s4_write_idle_rel", r.idle, 27);
    c0 = cyc;
    run_txn(c0, 30, 1'b0, r);
    check("s4_read_grant_rel", r.grant, 1);
    check("s4_read_is_read", r.is_write, 0);
    check("s4_read_camb_count", r.n_camb, 3);
    term_esc = 1'b0;
    term_lect = 1'b0;
    tick();

    // Reset in the middle of F_DAT abandons the transaction.
    req_lect = 1'b1;
    tick();
    req_lect = 1'b0;
    repeat (6) tick();
    check("s5_in_dat", {dat, ocupado}, 2'b01);
    reset = 1'b0;
    #1;
    check("s5_outputs_in_reset", {lectura, escritura, dir, dat, camb, ocupado, err_timeout}, 7'b0);
    repeat (2) tick();
    reset = 1'b1;
    quiet = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (lectura || escritura || dir || dat || camb || ocupado) quiet++;
    end
    check("s5_quiet_after_release", quiet, 0);
    c0 = cyc; req_lect = 1'b1;
    run_txn(c0, 20, 1'b0, r);
    check("s5_new_read_grant_rel", r.grant, 1);
    check("s5_new_read_idle_rel", r.idle, 27);
    term_lect = 1'b0;
    tick();

    // Random traffic with varying completion rates and rare resets.
    for (int seg = 0; seg < 8; seg++) begin
      int rate;
      rate = (seg % 3 == 0) ? 6 : ((seg % 3 == 1) ? 30 : 500);
      for (int i = 0; i < 900; i++) begin
        tick();
        req_esc = ($urandom_range(0, 39) == 0);
        req_lect = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, rate - 1) == 0) term_lect = ~term_lect;
        if ($urandom_range(0, rate - 1) == 0) term_esc = ~term_esc;
        if ($urandom_range(0, 2999) == 0) begin
          reset = 1'b0;
          tick();
          reset = 1'b1;
        end
      end
    end
    req_esc = 1'b0;
    req_lect = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/control_maestro.md
CONTROL_MAESTRO -- requirements
Module: control_maestro

Interface
Parameters:
REQ-001 The block SHALL have parameter T_FASE, default 4: cycles per bus phase (DIR, DAT, cambio), range 2..255.
REQ-002 The block SHALL have parameter T_REFRESCO, default 1000: cycles between automatic read transactions, range 16..2^20.
REQ-003 The block SHALL have parameter MAX_PASOS, default 16: maximum cambio strobes per transaction before abort.
Ports:
REQ-004 clk  in  1  single system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 Req_Esc  in  1  level write request from user/configuration logic.
REQ-007 Req_Lect  in  1  level on-demand read request.
REQ-008 Term_Lect, Term_Esc  in  1 each  done flags from read and write machines; may stay high after completion.
REQ-009 Lectura, Escritura  out  1 each  one-cycle start pulse to read and write machines.
REQ-010 DIR, DAT, cambio_estado  out  1 each  one-cycle phase strobes shared by both machines.
REQ-011 Ocupado  out  1  high from grant until return to IDLE.
REQ-012 Err_Timeout  out  1  sticky abort flag, cleared on next grant.

Function
REQ-013 States SHALL be IDLE, GRANT, F_DIR, F_DAT, F_CAMB, FIN; encoding free, unused codes SHALL go to IDLE.
REQ-014 Refresh counter SHALL count clk cycles in every state; at T_REFRESCO-1 it SHALL wrap to 0 and set pend_lect.
REQ-015 Req_Lect high in IDLE SHALL set pend_lect; Req_Esc high in IDLE SHALL set pend_esc.
REQ-016 Arbitration in IDLE: pend_esc wins over pend_lect; loser stays pending; no request is dropped.
REQ-017 IDLE -> GRANT when any pending bit is set; GRANT lasts 1 cycle and pulses Escritura or Lectura for the winner, clears its pending bit, clears Err_Timeout, and latches the owner.
REQ-018 GRANT -> F_DIR; each of F_DIR, F_DAT, F_CAMB SHALL last exactly T_FASE cycles, with its strobe high only in the first cycle.
REQ-019 A rising-edge detector SHALL watch the owner's Term flag (previous value registered); an edge in any transaction state SHALL set done_lat.
REQ-020 At the end of F_CAMB: done_lat set -> FIN; else step counter +1 and -> F_DIR.
REQ-021 If step counter reaches MAX_PASOS without done_lat: -> FIN and set Err_Timeout.
REQ-022 FIN SHALL last 1 cycle, clear done_lat and step counter, then -> IDLE; Ocupado low from the IDLE cycle on.
REQ-023 Requests arriving while Ocupado SHALL set pending bits and be served after FIN; a refresh wrap during a read transaction SHALL set pend_lect (one extra read, not lost).
REQ-024 Req_Esc and refresh wrap in the same IDLE cycle: write granted first, read next.
REQ-025 Strobes SHALL be mutually exclusive; at most one of DIR, DAT, cambio_estado, Lectura, Escritura high per cycle.
REQ-026 All outputs SHALL be driven from registers.

Reset
REQ-027 reset low SHALL immediately force IDLE, all strobes 0, Ocupado 0, Err_Timeout 0, pending bits 0, counters 0, edge-detector history 0.
REQ-028 Reset mid-transaction SHALL abandon it with no further strobes; after release, the first grant occurs only on a new request or refresh wrap.

Verification
REQ-029 Req_Lect pulse in IDLE, T_FASE=4 -> Lectura at cycle 1, DIR at 2, DAT at 6, cambio_estado at 10; repeats every 12 cycles until Term_Lect rises.
REQ-030 Term_Lect rises during the 8th step -> FIN after that F_CAMB; Ocupado drops; exactly 8 cambio_estado pulses; Err_Timeout=0.
REQ-031 Req_Esc and refresh wrap in the same cycle -> Escritura first; after FIN, Lectura with no extra refresh delay.
REQ-032 Term never rises, MAX_PASOS=16 -> 16 cambio_estado pulses, then FIN, Err_Timeout=1; next grant clears it.
REQ-033 reset low during F_DAT -> outputs 0 within the same cycle; no strobes after release until a new request.
REQ-034 Term_Lect held high from a prior read -> new read is not ended early; only a fresh 0->1 edge completes it.
